// File: rtl/ramp_quantizer.sv
`timescale 1ns/1ps
// ramp_quantizer
//   Digital back end of the 4-step thermometer-ramp converter. Re-aligns the
//   DAC step index with the synchronised comparator decision, counts "above"
//   decisions over one ramp (code 0..4), sums NAVG codes and hands the sum
//   to the consumer over a valid/ready handshake.
//
//   Ports
//     clk         system clock, rising edge
//     rst         asynchronous reset, active low
//     count[2:0]  DAC step index, nominally 0,1,2,3,4,0,...
//     cmp         raw comparator output (vin above DAC level), async to clk
//     start       single-cycle request to begin an accumulation
//     res_ready   consumer accepts the result
//     busy        high while syncing, sampling or holding a result
//     res_valid   result available
//     res_sum     sum of NAVG codes
//     res_bubble  a non-monotonic comparator pattern occurred in this result
//     seq_err     one-cycle pulse when the aligned step index breaks sequence
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start
//   SYNC   | waiting for aligned step 0 to begin a conversion
//   SAMPLE | walking aligned steps 1..4, counting cmp_s
//   DONE   | result held until res_valid & res_ready
module ramp_quantizer #(
    parameter int LAT   = 3,
    parameter int NAVG  = 4,
    parameter int SUM_W = 3 + $clog2(NAVG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       count,
    input  logic             cmp,
    input  logic             start,
    input  logic             res_ready,
    output logic             busy,
    output logic             res_valid,
    output logic [SUM_W-1:0] res_sum,
    output logic             res_bubble,
    output logic             seq_err
);

    localparam int CNT_W = $clog2(NAVG) + 1;
    localparam logic [CNT_W-1:0] LAST_CONV = CNT_W'(NAVG - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state, state_nxt;
    logic             cmp_meta, cmp_s;
    logic [2:0]       count_dl [LAT];
    logic [2:0]       count_d;
    logic [2:0]       exp_step;
    logic [2:0]       code, code_nxt;
    logic             seen0;
    logic [CNT_W-1:0] conv;
    logic [SUM_W-1:0] acc;
    logic             bubble;
    logic             hit;
    logic             clear_acc;

    // The delay line resets to 7, a value the DAC never produces, so the
    // FSM cannot lock onto a false step 0 straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
            for (int i = 0; i < LAT; i++) count_dl[i] <= 3'd7;
        end else begin
            cmp_meta    <= cmp;
            cmp_s       <= cmp_meta;
            count_dl[0] <= count;
            for (int i = 1; i < LAT; i++) count_dl[i] <= count_dl[i-1];
        end
    end

    assign count_d   = count_dl[LAT-1];
    assign hit       = (count_d == exp_step);
    assign code_nxt  = code + {2'b00, cmp_s};
    assign clear_acc = start && ((state == IDLE) || (state == DONE && res_ready));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SYNC;
            SYNC:    if (count_d == 3'd0) state_nxt = SAMPLE;
            SAMPLE: begin
                if (!hit)
                    state_nxt = SYNC;
                else if (exp_step == 3'd4)
                    state_nxt = (conv == LAST_CONV) ? DONE : SYNC;
            end
            DONE:    if (res_ready) state_nxt = start ? SYNC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            seq_err   <= 1'b0;
            acc       <= '0;
            conv      <= '0;
            bubble    <= 1'b0;
            code      <= '0;
            seen0     <= 1'b0;
            exp_step  <= 3'd1;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            res_valid <= (state_nxt == DONE);
            seq_err   <= (state == SAMPLE) && !hit;

            if (clear_acc) begin
                acc    <= '0;
                conv   <= '0;
                bubble <= 1'b0;
            end

            if (state == SYNC && count_d == 3'd0) begin
                code     <= '0;
                seen0    <= 1'b0;
                exp_step <= 3'd1;
            end

            // On a mismatch nothing here updates: the partial code is simply
            // abandoned and SYNC re-initialises it for the next ramp.
            if (state == SAMPLE && hit) begin
                code     <= code_nxt;
                exp_step <= exp_step + 3'd1;
                if (!cmp_s)
                    seen0 <= 1'b1;
                if (cmp_s && seen0)
                    bubble <= 1'b1;
                if (exp_step == 3'd4) begin
                    acc  <= acc + SUM_W'(code_nxt);
                    conv <= conv + 1'b1;
                end
            end
        end
    end

    assign res_sum    = acc;
    assign res_bubble = bubble;

endmodule
